// File: rtl/stm_tx_frame_mux.sv
`default_nettype none
// ============================================================================
// Module  : stm_tx_frame_mux
// Brief   : STM-N transmit frame counter, registered source read-enable decode
//           and two-stage byte-interleaved output mux. Defining SCRAMBLE_EN adds
//           the frame-synchronous x^7+x^6+1 scrambler (requires WID = 8).
// Rev     : 1.0  initial release
// ============================================================================
module stm_tx_frame_mux #(
   parameter int              WID    = 8,
   parameter int              NSTS   = 3,
   parameter int              RWID   = 4,
   parameter int              CWID   = 7,
   parameter int              SWID   = 2,
   parameter int              AUPROW = 3,
   parameter logic [WID-1:0]  FILL   = {WID{1'b0}}
) (
   input  logic                 clk19,
   input  logic                 rst,
   input  logic                 fsync,
   input  logic [NSTS-1:0]      tug3act,
   output logic [RWID-1:0]      row,
   output logic [CWID-1:0]      col,
   output logic [SWID-1:0]      sts,
   output logic                 stmen,
   input  logic [WID-1:0]       stmdi,
   output logic                 au4en,
   input  logic [WID-1:0]       au4di,
   output logic                 vc4en,
   input  logic [WID-1:0]       vc4di,
   output logic [NSTS-1:0]      tug3en,
   input  logic [NSTS*WID-1:0]  tug3di,
   output logic [WID-1:0]       dataout,
   output logic                 fpout,
   output logic                 slip
);

   localparam logic [RWID-1:0] c_row_last = RWID'(8);
   localparam logic [CWID-1:0] c_col_last = CWID'(89);
   localparam logic [SWID-1:0] c_sts_last = SWID'(NSTS - 1);
   localparam logic [RWID-1:0] c_aup_row  = RWID'(AUPROW);

   localparam logic [2:0] c_sel_none = 3'd0;
   localparam logic [2:0] c_sel_stm  = 3'd1;
   localparam logic [2:0] c_sel_au4  = 3'd2;
   localparam logic [2:0] c_sel_vc4  = 3'd3;
   localparam logic [2:0] c_sel_tug  = 3'd4;
   localparam logic [2:0] c_sel_fill = 3'd5;

   logic [RWID-1:0] r_row, w_nrow;
   logic [CWID-1:0] r_col, w_ncol;
   logic [SWID-1:0] r_sts, w_nsts;
   logic            w_at_end;

   logic            r_stmen, r_au4en, r_vc4en, r_slip;
   logic [NSTS-1:0] r_tug3en, w_tug3en;
   logic            w_stmen, w_au4en, w_vc4en;
   logic [2:0]      r_sel1, w_sel1, r_sel2;
   logic [SWID-1:0] r_sts2;
   logic            w_fp1, r_fp2, r_fp;
   logic [WID-1:0]  w_tug, w_mux, w_byte, r_dout;

   // Next position: sts fastest, then col, then row; fsync forces (0,0,0).
   always_comb begin
      w_at_end = (r_row == c_row_last) && (r_col == c_col_last) && (r_sts == c_sts_last);
      w_nrow   = r_row;
      w_ncol   = r_col;
      w_nsts   = r_sts + SWID'(1);
      if (fsync) begin
         w_nrow = '0;
         w_ncol = '0;
         w_nsts = '0;
      end else if (r_sts == c_sts_last) begin
         w_nsts = '0;
         if (r_col == c_col_last) begin
            w_ncol = '0;
            w_nrow = (r_row == c_row_last) ? '0 : r_row + RWID'(1);
         end else begin
            w_ncol = r_col + CWID'(1);
         end
      end
   end

   // Enables decode the position being loaded so they line up with row/col/sts.
   always_comb begin
      w_stmen  = (w_ncol <= CWID'(2)) && (w_nrow != c_aup_row);
      w_au4en  = (w_ncol <= CWID'(2)) && (w_nrow == c_aup_row);
      w_vc4en  = (w_ncol >= CWID'(3)) && (w_ncol <= CWID'(5));
      w_tug3en = '0;
      for (int k = 0; k < NSTS; k++) begin
         w_tug3en[k] = (w_ncol >= CWID'(6)) && (w_nsts == SWID'(k)) && tug3act[k];
      end
      if (w_stmen)            w_sel1 = c_sel_stm;
      else if (w_au4en)       w_sel1 = c_sel_au4;
      else if (w_vc4en)       w_sel1 = c_sel_vc4;
      else if (|w_tug3en)     w_sel1 = c_sel_tug;
      else                    w_sel1 = c_sel_fill;
   end

   assign w_fp1 = (r_row == '0) && (r_col == '0) && (r_sts == '0);

   always_comb begin
      w_tug = '0;
      for (int k = 0; k < NSTS; k++) begin
         if (r_sts2 == SWID'(k)) w_tug = tug3di[k*WID +: WID];
      end
      case (r_sel2)
         c_sel_stm:  w_mux = stmdi;
         c_sel_au4:  w_mux = au4di;
         c_sel_vc4:  w_mux = vc4di;
         c_sel_tug:  w_mux = w_tug;
         c_sel_fill: w_mux = FILL;
         default:    w_mux = '0;
      endcase
   end

`ifdef SCRAMBLE_EN
   logic           w_nosc1, w_init1, r_nosc2, r_init2;
   logic [6:0]     r_scr, w_scr;
   logic [WID-1:0] w_key;

   assign w_nosc1 = (r_row == '0) && (r_col <= CWID'(2));
   assign w_init1 = (r_row == '0) && (r_col == CWID'(3)) && (r_sts == '0);

   // Key bits leave MSB first; the byte at (0,3,0) is keyed from the 7'h7F seed.
   always_comb begin
      w_scr = r_init2 ? 7'h7F : r_scr;
      w_key = '0;
      for (int b = WID - 1; b >= 0; b--) begin
         w_key[b] = w_scr[6];
         w_scr    = {w_scr[5:0], w_scr[6] ^ w_scr[5]};
      end
      w_byte = r_nosc2 ? w_mux : (w_mux ^ w_key);
   end

   always_ff @(posedge clk19 or posedge rst) begin
      if (rst) begin
         r_nosc2 <= 1'b0;
         r_init2 <= 1'b0;
         r_scr   <= 7'h7F;
      end else begin
         r_nosc2 <= w_nosc1;
         r_init2 <= w_init1;
         if (r_sel2 != c_sel_none) r_scr <= w_scr;
      end
   end
`else
   assign w_byte = w_mux;
`endif

   always_ff @(posedge clk19 or posedge rst) begin
      if (rst) begin
         r_row    <= c_row_last;
         r_col    <= c_col_last;
         r_sts    <= c_sts_last;
         r_stmen  <= 1'b0;
         r_au4en  <= 1'b0;
         r_vc4en  <= 1'b0;
         r_tug3en <= '0;
         r_sel1   <= c_sel_none;
         r_slip   <= 1'b0;
         r_sel2   <= c_sel_none;
         r_sts2   <= '0;
         r_fp2    <= 1'b0;
         r_fp     <= 1'b0;
         r_dout   <= '0;
      end else begin
         r_row    <= w_nrow;
         r_col    <= w_ncol;
         r_sts    <= w_nsts;
         r_stmen  <= w_stmen;
         r_au4en  <= w_au4en;
         r_vc4en  <= w_vc4en;
         r_tug3en <= w_tug3en;
         r_sel1   <= w_sel1;
         r_slip   <= fsync && !w_at_end;
         r_sel2   <= r_sel1;
         r_sts2   <= r_sts;
         r_fp2    <= w_fp1;
         r_fp     <= r_fp2;
         r_dout   <= (r_sel2 == c_sel_none) ? '0 : w_byte;
      end
   end

   assign row     = r_row;
   assign col     = r_col;
   assign sts     = r_sts;
   assign stmen   = r_stmen;
   assign au4en   = r_au4en;
   assign vc4en   = r_vc4en;
   assign tug3en  = r_tug3en;
   assign dataout = r_dout;
   assign fpout   = r_fp;
   assign slip    = r_slip;

endmodule
`default_nettype wire

// File: tb/tb_stm_tx_frame_mux.sv
`default_nettype none
// ============================================================================
// Module  : tb_stm_tx_frame_mux
// Brief   : Randomised self-checking bench; expected outputs come from a frame
//           index model (row/col/sts derived arithmetically from one counter).
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stm_tx_frame_mux;
   localparam int             WID    = 8;
   localparam int             NSTS   = 3;
   localparam int             RWID   = 4;
   localparam int             CWID   = 7;
   localparam int             SWID   = 2;
   localparam int             AUPROW = 3;
   localparam logic [WID-1:0] FILL   = 8'h00;
   localparam int             L      = 9 * 90 * NSTS;
   localparam int             ZW     = 3 + NSTS + WID + 2;
   localparam int             VW     = RWID + CWID + SWID + ZW;
   localparam logic [VW-1:0]  RST_V  = {RWID'(8), CWID'(89), SWID'(NSTS - 1), ZW'(0)};

   logic                clk19 = 1'b0;
   logic                rst   = 1'b1;
   logic                fsync = 1'b0;
   logic [NSTS-1:0]     tug3act = '1;
   logic [WID-1:0]      stmdi = '0, au4di = '0, vc4di = '0;
   logic [NSTS*WID-1:0] tug3di = '0;
   logic [RWID-1:0]     row;
   logic [CWID-1:0]     col;
   logic [SWID-1:0]     sts;
   logic                stmen, au4en, vc4en, fpout, slip;
   logic [NSTS-1:0]     tug3en;
   logic [WID-1:0]      dataout;

   stm_tx_frame_mux #(
      .WID(WID), .NSTS(NSTS), .RWID(RWID), .CWID(CWID), .SWID(SWID),
      .AUPROW(AUPROW), .FILL(FILL)
   ) dut (
      .clk19(clk19), .rst(rst), .fsync(fsync), .tug3act(tug3act),
      .row(row), .col(col), .sts(sts),
      .stmen(stmen), .stmdi(stmdi), .au4en(au4en), .au4di(au4di),
      .vc4en(vc4en), .vc4di(vc4di), .tug3en(tug3en), .tug3di(tug3di),
      .dataout(dataout), .fpout(fpout), .slip(slip)
   );

   always #5 clk19 = ~clk19;

   wire [VW-1:0] obs = {row, col, sts, stmen, au4en, vc4en, tug3en, dataout, fpout, slip};

   logic [VW-1:0]   exp_v;
   int              checks = 0;
   int              errors = 0;
   int              cyc    = 0;
   int              n      = L - 1;     // frame index of the current position
   int              hp[2];              // frame index of the two bytes in flight
   logic [NSTS-1:0] ha[2];
   bit              hv[2];
   int              dmode  = 0;         // 0 random data, 1 fixed pattern, 2 all zero
`ifdef SCRAMBLE_EN
   bit              seqb[127];
   int              kb = 0;
`endif

   task automatic model_reset();
      n = L - 1;
      hv[0] = 1'b0;
      hv[1] = 1'b0;
   endtask

   // Drives one cycle of stimulus and predicts every output after the next edge.
   task automatic advance(input bit f, input logic [NSTS-1:0] act);
      logic [WID-1:0]      ds, da, dv, eb;
      logic [NSTS*WID-1:0] dt;
      logic [NSTS-1:0]     een;
      int                  prev, nr, nc, ns, r, c, s;
      bit                  es, ea, ev, efp;
      ds = '0; da = '0; dv = '0; dt = '0;
      if (dmode == 0) begin
         ds = WID'($urandom); da = WID'($urandom); dv = WID'($urandom);
         for (int k = 0; k < NSTS; k++) dt[k*WID +: WID] = WID'($urandom);
      end else if (dmode == 1) begin
         ds = 8'h11; da = 8'h22; dv = 8'h33; dt = {8'h66, 8'h55, 8'h44};
      end
      fsync = f; tug3act = act; stmdi = ds; au4di = da; vc4di = dv; tug3di = dt;
      @(posedge clk19); #1;
      cyc++;
      prev = n;
      n  = f ? 0 : (n + 1) % L;
      nr = n / (90 * NSTS);
      nc = (n / NSTS) % 90;
      ns = n % NSTS;
      es = (nc <= 2) && (nr != AUPROW);
      ea = (nc <= 2) && (nr == AUPROW);
      ev = (nc >= 3) && (nc <= 5);
      een = '0;
      if (nc >= 6 && act[ns]) een[ns] = 1'b1;
      eb = '0; efp = 1'b0;
      if (hv[1]) begin
         r = hp[1] / (90 * NSTS);
         c = (hp[1] / NSTS) % 90;
         s = hp[1] % NSTS;
         if (c <= 2)          eb = (r == AUPROW) ? da : ds;
         else if (c <= 5)     eb = dv;
         else if (ha[1][s])   eb = dt[s*WID +: WID];
         else                 eb = FILL;
         efp = (hp[1] == 0);
`ifdef SCRAMBLE_EN
         if (hp[1] == 3 * NSTS) kb = 0;
         if (!(r == 0 && c <= 2))
            for (int j = 0; j < WID; j++) eb[WID-1-j] = eb[WID-1-j] ^ seqb[(8 * kb + j) % 127];
         kb++;
`endif
      end
      hp[1] = hp[0]; ha[1] = ha[0]; hv[1] = hv[0];
      hp[0] = n;     ha[0] = act;   hv[0] = 1'b1;
      exp_v = {RWID'(nr), CWID'(nc), SWID'(ns), es, ea, ev, een, eb, efp,
               bit'(f && prev != L - 1)};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk19);
      #1;
      checks++;
      if (obs !== RST_V) begin
         errors++;
         $display("FAIL reset_state obs=%h exp=%h", obs, RST_V);
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_sequence();
      int first = -1, last = -1;
      dmode = 0;
      for (int i = 0; i < 2 * L + 20; i++) begin
         advance(1'b0, '1);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL sequence cyc=%0d obs=%h exp=%h", cyc, obs, exp_v);
         end
         if (fpout === 1'b1) begin
            if (first < 0) first = i;
            if (last >= 0) begin
               checks++;
               if (i - last != L) begin
                  errors++;
                  $display("FAIL fp_period got=%0d want=%0d", i - last, L);
               end
            end
            last = i;
         end
      end
      checks++;
      if (first != 2) begin
         errors++;
         $display("FAIL first_fp got=%0d want=2", first);
      end
   endtask

   task automatic test_pattern();
      dmode = 1;
      for (int i = 0; i < L + 10; i++) begin
         advance(1'b0, 3'b111);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL pattern cyc=%0d obs=%h exp=%h", cyc, obs, exp_v);
         end
      end
   endtask

   task automatic test_inactive();
      int en1 = 0;
      dmode = 0;
      for (int i = 0; i < L + 10; i++) begin
         advance(1'b0, 3'b101);
         if (tug3en[1] === 1'b1) en1++;
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL inactive cyc=%0d obs=%h exp=%h", cyc, obs, exp_v);
         end
      end
      checks++;
      if (en1 != 0) begin
         errors++;
         $display("FAIL tug3en1_count got=%0d want=0", en1);
      end
   endtask

   task automatic test_random();
      dmode = 0;
      for (int i = 0; i < 2 * L; i++) begin
         advance(($urandom_range(0, 399) == 0), NSTS'($urandom));
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL random cyc=%0d obs=%h exp=%h", cyc, obs, exp_v);
         end
      end
   endtask

   // Runs until the model sits at frame index tgt; reports a timeout as a failure.
   task automatic run_to(input int tgt);
      for (int i = 0; i < 2 * L && n != tgt; i++) begin
         advance(1'b0, '1);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL run_to cyc=%0d obs=%h exp=%h", cyc, obs, exp_v);
         end
      end
      checks++;
      if (n != tgt) begin
         errors++;
         $display("FAIL run_to_timeout got=%0d want=%0d", n, tgt);
      end
   endtask

   task automatic test_fsync();
      dmode = 0;
      run_to(4 * 90 * NSTS + 20 * NSTS + 1);
      advance(1'b1, '1);
      checks++;
      if (slip !== 1'b1 || row !== '0 || col !== '0 || sts !== '0) begin
         errors++;
         $display("FAIL fsync_mid slip=%b pos=%0d,%0d,%0d want slip=1 pos=0,0,0", slip, row, col, sts);
      end
      for (int i = 0; i < 2; i++) begin
         advance(1'b0, '1);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL fsync_after cyc=%0d obs=%h exp=%h", cyc, obs, exp_v);
         end
      end
      checks++;
      if (fpout !== 1'b1) begin
         errors++;
         $display("FAIL fsync_fp got=%b want=1", fpout);
      end
      run_to(L - 1);
      advance(1'b1, '1);
      checks++;
      if (slip !== 1'b0 || obs !== exp_v) begin
         errors++;
         $display("FAIL fsync_wrap slip=%b obs=%h exp=%h", slip, obs, exp_v);
      end
      for (int i = 0; i < 5; i++) begin
         advance(1'b1, '1);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL fsync_hold cyc=%0d obs=%h exp=%h", cyc, obs, exp_v);
         end
      end
   endtask

   task automatic test_async_reset();
      dmode = 0;
      run_to(6 * 90 * NSTS + 50 * NSTS + 2);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (obs !== RST_V) begin
         errors++;
         $display("FAIL async_reset obs=%h exp=%h", obs, RST_V);
      end
      @(posedge clk19); #1;
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 6; i++) begin
         advance(1'b0, '1);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL after_reset cyc=%0d obs=%h exp=%h", cyc, obs, exp_v);
         end
      end
   endtask

   task automatic test_zero_data();
      dmode = 2;
      for (int i = 0; i < L + 10; i++) begin
         advance(1'b0, '1);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL zero_data cyc=%0d obs=%h exp=%h", cyc, obs, exp_v);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef SCRAMBLE_EN
      for (int i = 0; i < 127; i++) seqb[i] = (i < 7) ? 1'b1 : (seqb[i-7] ^ seqb[i-6]);
`endif
      test_reset();
      test_sequence();
      test_pattern();
      test_inactive();
      test_fsync();
      test_random();
      test_async_reset();
      test_zero_data();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
